// File: rtl/palette_ram_dp.sv
// Palette lookup RAM: one write port, two registered read ports with
// write-first bypass, plus a hardware clear engine that sweeps the array.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wr_en/addr/data      host write port
//   wr_drop              1-cycle pulse when a write is discarded (busy)
//   rd_en_x/rd_addr_x    pixel-pipe read request, x = a|b
//   rd_data_x/rd_valid_x registered read response, 1 cycle latency
//   clear_req            request a full clear sweep (sampled in IDLE)
//   busy                 clear sweep in progress
module palette_ram_dp #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              clear_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_a_d;
  logic              rd_valid_b_q, rd_valid_b_d;
  logic              wr_drop_q, wr_drop_d;

  // State register. busy tracks the next state so it
  // is exactly aligned with state_q == CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= (state_d == CLEAR);
    end
  end

  // Next-state logic. clear_req is ignored mid-sweep.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_ptr_q == LAST) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // While sweeping the array is logically clear, so
  // reads short-circuit to CLEAR_VAL. In IDLE a write
  // to the same address wins over the stored word.
  function automatic logic [DATA_W-1:0] rd_word(
    input logic              sweeping,
    input logic [ADDR_W-1:0] addr
  );
    logic [DATA_W-1:0] w;
    w = mem[addr];
    if (sweeping) begin
      w = CLEAR_VAL;
    end else if (wr_en && (wr_addr == addr)) begin
      w = wr_data;
    end
    return w;
  endfunction

  // Output / datapath logic.
  always_comb begin
    mem_we       = 1'b0;
    mem_wa       = wr_addr;
    mem_wd       = wr_data;
    wr_drop_d    = 1'b0;
    rd_valid_a_d = rd_en_a;
    rd_valid_b_d = rd_en_b;
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;

    unique case (state_q)
      IDLE: begin
        mem_we = wr_en;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_ptr_q;
        mem_wd    = CLEAR_VAL;
        wr_drop_d = wr_en;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase

    if (rd_en_a) begin
      rd_data_a_d = rd_word(state_q == CLEAR, rd_addr_a);
    end
    if (rd_en_b) begin
      rd_data_b_d = rd_word(state_q == CLEAR, rd_addr_b);
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Registered read and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign wr_drop    = wr_drop_q;
  assign busy       = busy_q;

endmodule
